// File: rtl/truth_table_checker_if.sv
// Bus between the stimulus side (master) and the truth-table checker (slave):
// code/F sample inputs plus the capture results.
interface truth_table_checker_if;
  logic        start;
  logic        sample;
  logic        X4;
  logic        X3;
  logic        X2;
  logic        X1;
  logic        X0;
  logic        F;
  logic [31:0] table_out;
  logic [31:0] seen;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  mismatch_count;
  logic [4:0]  first_err_idx;
  logic        unstable;

  modport master (
    output start, sample, X4, X3, X2, X1, X0, F,
    input  table_out, seen, busy, done, pass, mismatch_count, first_err_idx, unstable
  );

  modport slave (
    input  start, sample, X4, X3, X2, X1, X0, F,
    output table_out, seen, busy, done, pass, mismatch_count, first_err_idx, unstable
  );
endinterface

// File: rtl/truth_table_checker.sv
// Rebuilds the 32-entry truth table of a 5-input function from (code, F)
// samples, compares the first capture of each code against EXPECTED, and
// flags codes whose later samples disagree with their first capture.
module truth_table_checker #(
  parameter logic [31:0] EXPECTED = 32'hA5A5_0F0F
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] table_q, table_d;
  logic [31:0] seen_q, seen_d;
  logic [5:0]  mcnt_q, mcnt_d;
  logic [4:0]  ferr_q, ferr_d;
  logic        unst_q, unst_d;
  logic        pass_q, pass_d;
  logic [4:0]  idx;

  assign idx = {bus.X4, bus.X3, bus.X2, bus.X1, bus.X0};

  // State and result registers; synchronous reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      table_q <= '0;
      seen_q  <= '0;
      mcnt_q  <= '0;
      ferr_q  <= '0;
      unst_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      seen_q  <= seen_d;
      mcnt_q  <= mcnt_d;
      ferr_q  <= ferr_d;
      unst_q  <= unst_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and result update; start always wins over a coincident sample.
  always_comb begin
    state_d = state_q;
    table_d = table_q;
    seen_d  = seen_q;
    mcnt_d  = mcnt_q;
    ferr_d  = ferr_q;
    unst_d  = unst_q;
    pass_d  = pass_q;

    if (bus.start) begin
      state_d = CAPTURE;
      table_d = '0;
      seen_d  = '0;
      mcnt_d  = '0;
      ferr_d  = '0;
      unst_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (bus.sample) begin
            if (!seen_q[idx]) begin
              table_d[idx] = bus.F;
              seen_d[idx]  = 1'b1;
              if (bus.F != EXPECTED[idx]) begin
                if (mcnt_q == '0) ferr_d = idx;
                mcnt_d = mcnt_q + 6'd1;
              end
            end else if (bus.F != table_q[idx]) begin
              unst_d = 1'b1;
            end
            // pass is computed from the post-update results so it lands
            // together with the DONE transition.
            if (seen_d == '1) begin
              state_d = DONE;
              pass_d  = (mcnt_d == '0) && !unst_d;
            end
          end
        end
        default: ; // IDLE and DONE ignore samples
      endcase
    end
  end

  assign bus.table_out      = table_q;
  assign bus.seen           = seen_q;
  assign bus.busy           = (state_q == CAPTURE);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = pass_q;
  assign bus.mismatch_count = mcnt_q;
  assign bus.first_err_idx  = ferr_q;
  assign bus.unstable       = unst_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a short vector table for
// single-cycle behaviour plus hand-written sweeps for full runs.
module tb_truth_table_checker;

  localparam logic [31:0] EXP = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  truth_table_checker_if bus ();

  truth_table_checker #(.EXPECTED(32'hA5A5_0F0F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        sample;
    logic [4:0]  code;
    logic        f;
    logic        e_busy;
    logic        e_done;
    logic [5:0]  e_cnt;
    logic [4:0]  e_ferr;
    logic        e_unst;
    logic [31:0] e_seen;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge; return 1ns after the next posedge.
  task automatic tick(input logic s, input logic smp, input logic [4:0] code, input logic f);
    @(negedge clk);
    bus.start  = s;
    bus.sample = smp;
    {bus.X4, bus.X3, bus.X2, bus.X1, bus.X0} = code;
    bus.F = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sample = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full sweep; fmask inverts F at marked codes, dup re-samples one code
  // with inverted F right after its first sample.
  task automatic sweep(input logic [31:0] fmask, input bit desc, input bit gaps, input int dup);
    logic [4:0] code;
    for (int i = 0; i < 32; i++) begin
      code = desc ? 5'(31 - i) : 5'(i);
      tick(1'b0, 1'b1, code, EXP[code] ^ fmask[code]);
      if (i < 31) begin
        chk("sweep_done_low", {31'b0, bus.done}, 32'd0);
        chk("sweep_busy", {31'b0, bus.busy}, 32'd1);
      end
      if (dup == int'(code)) tick(1'b0, 1'b1, code, ~EXP[code]);
      if (gaps) tick(1'b0, 1'b0, 5'd0, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_table"}, bus.table_out, 32'd0);
    chk({nm, "_seen"}, bus.seen, 32'd0);
    chk({nm, "_cnt"}, {26'b0, bus.mismatch_count}, 32'd0);
    chk({nm, "_ferr"}, {27'b0, bus.first_err_idx}, 32'd0);
    chk({nm, "_flags"}, {28'b0, bus.unstable, bus.busy, bus.done, bus.pass}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sample = 1'b0;
    {bus.X4, bus.X3, bus.X2, bus.X1, bus.X0} = 5'd0;
    bus.F = 1'b0;

    // EXP[5]=0, EXP[9]=1, EXP[2]=1
    vecs[0] = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 6'd1, 5'd5, 1'b0, 32'h0000_0020};
    vecs[2] = '{1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 6'd2, 5'd5, 1'b0, 32'h0000_0220};
    vecs[3] = '{1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 6'd2, 5'd5, 1'b0, 32'h0000_0220};
    vecs[4] = '{1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 6'd2, 5'd5, 1'b1, 32'h0000_0220};
    vecs[5] = '{1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 6'd2, 5'd5, 1'b1, 32'h0000_0220};
    vecs[6] = '{1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 6'd0, 5'd0, 1'b0, 32'h0000_0000};
    vecs[7] = '{1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 6'd0, 5'd0, 1'b0, 32'h0000_0004};

    do_reset();
    chk_all_zero("reset");

    // Vector table: single-cycle behaviour
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].start, vecs[i].sample, vecs[i].code, vecs[i].f);
      chk($sformatf("vec%0d_busy", i), {31'b0, bus.busy}, {31'b0, vecs[i].e_busy});
      chk($sformatf("vec%0d_done", i), {31'b0, bus.done}, {31'b0, vecs[i].e_done});
      chk($sformatf("vec%0d_cnt", i), {26'b0, bus.mismatch_count}, {26'b0, vecs[i].e_cnt});
      chk($sformatf("vec%0d_ferr", i), {27'b0, bus.first_err_idx}, {27'b0, vecs[i].e_ferr});
      chk($sformatf("vec%0d_unst", i), {31'b0, bus.unstable}, {31'b0, vecs[i].e_unst});
      chk($sformatf("vec%0d_seen", i), bus.seen, vecs[i].e_seen);
    end

    // Clean ascending sweep
    do_reset();
    tick(1'b1, 1'b0, 5'd0, 1'b0);
    sweep(32'h0, 1'b0, 1'b0, -1);
    chk("t1_done", {31'b0, bus.done}, 32'd1);
    chk("t1_busy", {31'b0, bus.busy}, 32'd0);
    chk("t1_pass", {31'b0, bus.pass}, 32'd1);
    chk("t1_cnt", {26'b0, bus.mismatch_count}, 32'd0);
    chk("t1_table", bus.table_out, 32'hA5A5_0F0F);
    chk("t1_seen", bus.seen, 32'hFFFF_FFFF);
    chk("t1_unst", {31'b0, bus.unstable}, 32'd0);

    // Mismatches at codes 7 and 20
    tick(1'b1, 1'b0, 5'd0, 1'b0);
    sweep(32'h0010_0080, 1'b0, 1'b0, -1);
    chk("t2_cnt", {26'b0, bus.mismatch_count}, 32'd2);
    chk("t2_ferr", {27'b0, bus.first_err_idx}, 32'd7);
    chk("t2_table", bus.table_out, 32'hA5B5_0F8F);
    chk("t2_pass", {31'b0, bus.pass}, 32'd0);
    chk("t2_done", {31'b0, bus.done}, 32'd1);

    // Descending with gaps, code 3 re-sampled with wrong F
    tick(1'b1, 1'b0, 5'd0, 1'b0);
    sweep(32'h0, 1'b1, 1'b1, 3);
    chk("t3_unst", {31'b0, bus.unstable}, 32'd1);
    chk("t3_cnt", {26'b0, bus.mismatch_count}, 32'd0);
    chk("t3_table", bus.table_out, EXP);
    chk("t3_done", {31'b0, bus.done}, 32'd1);
    chk("t3_pass", {31'b0, bus.pass}, 32'd0);

    // Restart mid-run
    tick(1'b1, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 16; c++) tick(1'b0, 1'b1, 5'(c), EXP[c]);
    chk("t4_seen_half", bus.seen, 32'h0000_FFFF);
    tick(1'b1, 1'b0, 5'd0, 1'b0);
    chk("t4_seen_clr", bus.seen, 32'd0);
    chk("t4_cnt_clr", {26'b0, bus.mismatch_count}, 32'd0);
    chk("t4_busy", {31'b0, bus.busy}, 32'd1);
    sweep(32'h0, 1'b0, 1'b0, -1);
    chk("t4_done", {31'b0, bus.done}, 32'd1);
    chk("t4_pass", {31'b0, bus.pass}, 32'd1);

    // Reset mid-run, then samples without start
    tick(1'b1, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 11; c++) tick(1'b0, 1'b1, 5'(c), ~EXP[c]);
    do_reset();
    chk_all_zero("t5_rst");
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 5'(c), 1'b1);
    chk_all_zero("t5_ignored");

    // DONE holds; start+sample clears and discards the sample
    tick(1'b1, 1'b0, 5'd0, 1'b0);
    sweep(32'h0, 1'b0, 1'b0, -1);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 5'(c), ~EXP[c]);
    chk("t6_hold_table", bus.table_out, EXP);
    chk("t6_hold_cnt", {26'b0, bus.mismatch_count}, 32'd0);
    chk("t6_hold_flags", {28'b0, bus.unstable, bus.busy, bus.done, bus.pass}, 32'h3);
    tick(1'b1, 1'b1, 5'd5, 1'b1);
    chk("t6_seen", bus.seen, 32'd0);
    chk("t6_table", bus.table_out, 32'd0);
    chk("t6_flags", {28'b0, bus.unstable, bus.busy, bus.done, bus.pass}, 32'h4);
    chk("t6_cnt", {26'b0, bus.mismatch_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable response-side companion to the 5-input decoder/mux function block (inputs X4..X0, output F).
- The stimulus side walks the input code {X4,X3,X2,X1,X0}. This block observes each (code, F) pair on a sample strobe and rebuilds the 32-entry truth table.
- It compares the table against a parameterised expected table and reports coverage, mismatches and instability.
- Sits beside the function block in bench and board-level self-test.

Parameters:
- EXPECTED, 32'hA5A5_0F0F: expected truth table. Bit i is the expected F for code i = {X4,X3,X2,X1,X0}.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse. Clears all results and begins a capture run.
- sample  in  1  when high, X4..X0 and F are valid this cycle.
- X4  in  1  code bit 4 (MSB).
- X3  in  1  code bit 3.
- X2  in  1  code bit 2.
- X1  in  1  code bit 1.
- X0  in  1  code bit 0 (LSB).
- F  in  1  observed function output for the current code.
- table_out  out  32  captured F per code, indexed by code.
- seen  out  32  bit i set once code i has been sampled in this run.
- busy  out  1  high in CAPTURE state.
- done  out  1  high in DONE state.
- pass  out  1  valid when done. Equals (mismatch_count==0) && !unstable.
- mismatch_count  out  6  number of distinct codes whose first sample disagreed with EXPECTED (0..32).
- first_err_idx  out  5  code of the first mismatch in this run. 0 if none.
- unstable  out  1  sticky flag: a code was re-sampled with an F different from its first capture.

Behaviour:
- All registers update on the rising edge of clk only.
- Reset (rst=1), dominant over everything, any state, including mid-run:
  - state=IDLE.
  - table_out=0, seen=0, mismatch_count=0, first_err_idx=0.
  - unstable=0, busy=0, done=0, pass=0.
- States: IDLE, CAPTURE, DONE. Encoding is free.
- IDLE:
  - sample is ignored.
  - start=1 -> clear all results, go to CAPTURE.
- CAPTURE, on each cycle with sample=1, let idx={X4,X3,X2,X1,X0}:
  - If seen[idx]=0:
    - table_out[idx]<=F and seen[idx]<=1.
    - If F!=EXPECTED[idx]: mismatch_count+=1. If this is the first mismatch of the run (count was 0), first_err_idx<=idx.
  - If seen[idx]=1:
    - table_out is not rewritten and mismatch_count is unchanged.
    - If F!=table_out[idx], unstable<=1 (sticky until start or rst).
  - Completion: if the updated seen equals 32'hFFFF_FFFF, go to DONE on this edge. done and pass are visible the cycle after the completing sample (1-cycle latency).
  - Codes may arrive in any order and with gaps (sample=0 cycles). Ascending order with wrap from 31 to 0 is the normal case; wrap needs no special handling.
- DONE:
  - done=1. pass is registered with the done transition.
  - Outputs are held; sample is ignored.
  - start=1 -> clear all results, go to CAPTURE.
- start while in CAPTURE: abort the run, clear all results, remain in CAPTURE.
  - A sample in the same cycle as start is discarded.
- start and sample together in IDLE or DONE: start wins, sample discarded.
- mismatch_count saturates naturally at 32 (6-bit, max reachable 32). No overflow.
- pass=0 whenever done=0.

Test Plan:
- Default EXPECTED, rst then start, then codes 0..31 ascending, one per cycle, with F=EXPECTED[code].
  -> busy=1 during the run.
  -> done=1 exactly one cycle after code 31 is sampled.
  -> pass=1, mismatch_count=0, table_out=32'hA5A5_0F0F, seen=32'hFFFF_FFFF, unstable=0.
- Same sweep but F inverted at codes 7 and 20.
  -> mismatch_count=2, first_err_idx=7, table_out=32'hA5B5_0F8F, pass=0, done=1.
- Sweep with code 3 sampled twice: second sample has F=~EXPECTED[3]. Codes given in order 31 down to 0 with idle gaps.
  -> unstable=1, mismatch_count=0, table_out[3]=EXPECTED[3], done=1, pass=0.
- Sample codes 0..15, then start again, then a full correct sweep.
  -> after restart, seen=0 and count=0.
  -> done only after all 32 codes post-restart, pass=1.
- Sample codes 0..10, assert rst for 1 cycle, then drive samples without start.
  -> all outputs 0, state IDLE, samples ignored (seen stays 0).
- In DONE, drive sample with F mismatches, then start together with sample.
  -> DONE outputs unchanged until start.
  -> start clears results, the coincident sample is discarded (seen=0).
